// File: rtl/jtkcpu_busif_if.sv
// External board bus seen by jtkcpu_busif: address/data/lanes/strobe out,
// read data and DTACK back.
interface jtkcpu_busif_if #(
  parameter int AW = 24,
  parameter int DW = 8
) ();
  logic [AW-1:0]   addr;
  logic [DW-1:0]   dout;
  logic [DW-1:0]   din;
  logic [DW/8-1:0] bsel;
  logic            we;
  logic            as;
  logic            dtack;

  modport master (output addr, dout, bsel, we, as, input din, dtack);
  modport slave  (input addr, dout, bsel, we, as, output din, dtack);
endinterface

// File: rtl/jtkcpu_busif.sv
// KCPU external bus interface: splits a 1/2/4-byte CPU transfer into
// big-endian beats on an 8- or 16-bit bus with address strobe, DTACK wait
// states, minimum wait, DTACK timeout and halt gating.
module jtkcpu_busif #(
  parameter int AW       = 24,
  parameter int DW       = 8,
  parameter int WAIT_MIN = 0,
  parameter int TOUT     = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          halt,
  input  logic          req,
  input  logic          req_we,
  input  logic [1:0]    req_len,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic [31:0]   req_rdata,
  output logic          req_ack,
  output logic          err,
  output logic          busy,
  jtkcpu_busif_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

  state_t          r_st;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_dout;
  logic [DW/8-1:0] r_bsel;
  logic            r_we, r_as, r_ack, r_err, r_busy;
  logic            r_bad, r_single;
  logic [31:0]     r_wsh, r_mask, r_rdata;
  logic [2:0]      r_beats;
  logic [7:0]      r_cnt;

  logic [2:0]      w_bytes, w_beats;
  logic            w_bad, w_dtk, w_tout;
  logic [5:0]      w_pad;
  logic [31:0]     w_wsh, w_mask, w_wsh_nx, w_rd_beat;
  logic [DW-1:0]   w_dout_acc;
  logic [DW/8-1:0] w_bsel;
  logic [7:0]      w_rbyte;

  // Decode request length into byte and beat counts
  always_comb begin
    case (req_len)
      2'd1:    w_bytes = 3'd2;
      2'd3:    w_bytes = 3'd4;
      default: w_bytes = 3'd1;
    endcase
    if (DW == 16) w_beats = (w_bytes == 3'd1) ? 3'd1 : (w_bytes >> 1);
    else          w_beats = w_bytes;
  end

  // Multi-byte transfers must start on an even byte on a 16-bit bus
  assign w_bad = (DW == 16) && (w_bytes != 3'd1) && req_addr[0];

  // Left-align write data so the first beat is always the top DW bits;
  // the mask keeps read data right-aligned and zero-extended.
  assign w_pad    = 6'd32 - {w_bytes, 3'b000};
  assign w_wsh    = req_wdata << w_pad;
  assign w_mask   = 32'hFFFF_FFFF >> w_pad;
  assign w_wsh_nx = r_wsh << DW;

  // A lone byte goes on both lanes; bsel picks the live one
  assign w_dout_acc = (DW == 16 && w_bytes == 3'd1) ? {(DW/8){w_wsh[31:24]}}
                                                     : w_wsh[31 -: DW];

  generate
    if (DW == 16) begin : g_bsel16
      assign w_bsel = (w_bytes != 3'd1) ? 2'b11 : (req_addr[0] ? 2'b01 : 2'b10);
    end else begin : g_bsel8
      assign w_bsel = '1;
    end
  endgenerate

  // Read beat: single-lane beats shift in one byte, others the full bus
  assign w_rbyte   = r_addr[0] ? bus.din[7:0] : bus.din[DW-1 -: 8];
  assign w_rd_beat = (r_single ? ((r_rdata << 8) | {24'd0, w_rbyte})
                               : ((r_rdata << DW) | 32'(bus.din))) & r_mask;

  assign w_dtk  = bus.dtack && (r_cnt >= 8'(WAIT_MIN));
  assign w_tout = (TOUT != 0) && (({1'b0, r_cnt} + 9'd1) >= 9'(TOUT));

  // Transfer sequencer; every output is a register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st     <= IDLE;
      r_addr   <= '0;
      r_dout   <= '0;
      r_bsel   <= '0;
      r_we     <= 1'b0;
      r_as     <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_bad    <= 1'b0;
      r_single <= 1'b0;
      r_wsh    <= '0;
      r_mask   <= '0;
      r_rdata  <= '0;
      r_beats  <= '0;
      r_cnt    <= '0;
    end else begin
      // ack/err last one clk regardless of cen spacing
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (cen) begin
        case (r_st)
          IDLE: if (req && !halt) begin
            r_st     <= SETUP;
            r_busy   <= 1'b1;
            r_bad    <= w_bad;
            r_addr   <= req_addr;
            r_beats  <= w_beats;
            r_mask   <= w_mask;
            r_wsh    <= w_wsh;
            r_single <= (DW == 16) && (w_bytes == 3'd1);
            if (!w_bad) begin
              r_we   <= req_we;
              r_dout <= w_dout_acc;
              r_bsel <= w_bsel;
              if (!req_we) r_rdata <= r_rdata & w_mask;
            end
          end
          SETUP: begin
            if (r_bad) begin
              r_st   <= IDLE;
              r_ack  <= 1'b1;
              r_err  <= 1'b1;
              r_busy <= 1'b0;
            end else begin
              r_as  <= 1'b1;
              r_cnt <= '0;
              r_st  <= STROBE;
            end
          end
          STROBE: begin
            if (w_dtk) begin
              if (!r_we) r_rdata <= w_rd_beat;
              r_as <= 1'b0;
              if (r_beats > 3'd1) begin
                r_beats <= r_beats - 3'd1;
                r_addr  <= r_addr + AW'(DW/8);
                r_dout  <= w_wsh_nx[31 -: DW];
                r_wsh   <= w_wsh_nx;
                r_st    <= SETUP;
              end else begin
                r_st   <= IDLE;
                r_ack  <= 1'b1;
                r_busy <= 1'b0;
                r_we   <= 1'b0;
                r_bsel <= '0;
              end
            end else if (w_tout) begin
              // Drop remaining beats, keep any partial read data
              r_as   <= 1'b0;
              r_st   <= IDLE;
              r_ack  <= 1'b1;
              r_err  <= 1'b1;
              r_busy <= 1'b0;
              r_we   <= 1'b0;
              r_bsel <= '0;
            end else begin
              r_cnt <= (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
            end
          end
          default: r_st <= IDLE;
        endcase
      end
    end
  end

  assign req_rdata = r_rdata;
  assign req_ack   = r_ack;
  assign err       = r_err;
  assign busy      = r_busy;
  assign bus.addr  = r_addr;
  assign bus.dout  = r_dout;
  assign bus.bsel  = r_bsel;
  assign bus.we    = r_we;
  assign bus.as    = r_as;

endmodule

// File: tb/tb_jtkcpu_busif.sv
// Directed bench for jtkcpu_busif: one DW=8 zero-wait instance, one DW=16
// instance and one DW=8 WAIT_MIN=2 instance sharing the request inputs.
module tb_jtkcpu_busif;
  logic        clk = 1'b0;
  logic        rst_n, cen, halt, req_we;
  logic [2:0]  req;
  logic [1:0]  req_len;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;

  logic [31:0] rd8, rd16, rdw;
  logic        ack8, ack16, ackw, err8, err16, errw, busy8, busy16, busyw;

  int errors = 0;
  int checks = 0;
  int ascnt, ackn;

  jtkcpu_busif_if #(.AW(24), .DW(8))  b8();
  jtkcpu_busif_if #(.AW(24), .DW(16)) b16();
  jtkcpu_busif_if #(.AW(24), .DW(8))  bw();

  always #5 clk = ~clk;

  jtkcpu_busif #(.AW(24), .DW(8), .WAIT_MIN(0), .TOUT(15)) u8 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .halt(halt), .req(req[0]),
    .req_we(req_we), .req_len(req_len), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rdata(rd8), .req_ack(ack8), .err(err8),
    .busy(busy8), .bus(b8));

  jtkcpu_busif #(.AW(24), .DW(16), .WAIT_MIN(0), .TOUT(15)) u16 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .halt(halt), .req(req[1]),
    .req_we(req_we), .req_len(req_len), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rdata(rd16), .req_ack(ack16), .err(err16),
    .busy(busy16), .bus(b16));

  jtkcpu_busif #(.AW(24), .DW(8), .WAIT_MIN(2), .TOUT(15)) uw (
    .clk(clk), .rst_n(rst_n), .cen(cen), .halt(halt), .req(req[2]),
    .req_we(req_we), .req_len(req_len), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rdata(rdw), .req_ack(ackw), .err(errw),
    .busy(busyw), .bus(bw));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] sel, input logic we_i, input logic [1:0] len,
                       input logic [23:0] a, input logic [31:0] wd);
    req = sel; req_we = we_i; req_len = len; req_addr = a; req_wdata = wd;
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b1; halt = 1'b0; req = '0; req_we = 1'b0;
    req_len = '0; req_addr = '0; req_wdata = '0;
    b8.din = '0;  b8.dtack = 1'b0;
    b16.din = '0; b16.dtack = 1'b0;
    bw.din = '0;  bw.dtack = 1'b0;
    repeat (3) step();
    chk("rst_addr", 32'(b8.addr), 32'h0);
    chk("rst_as", 32'(b8.as), 32'h0);
    chk("rst_busy", 32'(busy8), 32'h0);
    chk("rst_rdata", rd8, 32'h0);
    chk("rst_ack", 32'(ack8), 32'h0);
    chk("rst_bsel16", 32'(b16.bsel), 32'h0);
    rst_n = 1'b1;
    step();

    // DW=8 two-byte read at 0x1234
    b8.dtack = 1'b1; b8.din = 8'hAB;
    issue(3'b001, 1'b0, 2'd1, 24'h001234, 32'h0);
    step(); req = '0;                                   // E0
    chk("r8_e0_addr", 32'(b8.addr), 32'h1234);
    chk("r8_e0_as", 32'(b8.as), 32'h0);
    chk("r8_e0_busy", 32'(busy8), 32'h1);
    step(); chk("r8_e1_as", 32'(b8.as), 32'h1);         // E1
    step();                                             // E2
    chk("r8_e2_as", 32'(b8.as), 32'h0);
    chk("r8_e2_addr", 32'(b8.addr), 32'h1235);
    chk("r8_e2_ack", 32'(ack8), 32'h0);
    b8.din = 8'hCD;
    step(); chk("r8_e3_as", 32'(b8.as), 32'h1);         // E3
    step();                                             // E4
    chk("r8_e4_ack", 32'(ack8), 32'h1);
    chk("r8_e4_err", 32'(err8), 32'h0);
    chk("r8_e4_rdata", rd8, 32'h0000ABCD);
    chk("r8_e4_busy", 32'(busy8), 32'h0);
    step(); chk("r8_e5_ack", 32'(ack8), 32'h0);

    // DW=16 four-byte write at 0x100
    b16.dtack = 1'b1;
    issue(3'b010, 1'b1, 2'd3, 24'h000100, 32'h11223344);
    step(); req = '0;
    chk("w16_e0_addr", 32'(b16.addr), 32'h100);
    chk("w16_e0_dout", 32'(b16.dout), 32'h1122);
    chk("w16_e0_bsel", 32'(b16.bsel), 32'h3);
    chk("w16_e0_we", 32'(b16.we), 32'h1);
    step(); chk("w16_e1_as", 32'(b16.as), 32'h1);
    step();
    chk("w16_e2_addr", 32'(b16.addr), 32'h102);
    chk("w16_e2_dout", 32'(b16.dout), 32'h3344);
    chk("w16_e2_as", 32'(b16.as), 32'h0);
    step();
    step();
    chk("w16_e4_ack", 32'(ack16), 32'h1);
    chk("w16_e4_we", 32'(b16.we), 32'h0);
    cen = 1'b0;
    step(); chk("w16_ack_1clk", 32'(ack16), 32'h0);
    cen = 1'b1;

    // DW=16 single byte read at odd address
    b16.din = 16'h55AA;
    issue(3'b010, 1'b0, 2'd0, 24'h000101, 32'h0);
    step(); req = '0;
    chk("b16_e0_bsel", 32'(b16.bsel), 32'h1);
    step();
    step();
    chk("b16_e2_ack", 32'(ack16), 32'h1);
    chk("b16_e2_rdata", rd16, 32'h000000AA);

    // DW=16 misaligned two-byte read
    issue(3'b010, 1'b0, 2'd1, 24'h000101, 32'h0);
    step(); req = '0;
    chk("bad_e0_as", 32'(b16.as), 32'h0);
    chk("bad_e0_busy", 32'(busy16), 32'h1);
    step();
    chk("bad_e1_ack", 32'(ack16), 32'h1);
    chk("bad_e1_err", 32'(err16), 32'h1);
    chk("bad_e1_as", 32'(b16.as), 32'h0);
    chk("bad_e1_busy", 32'(busy16), 32'h0);

    // WAIT_MIN=2: strobe held three cen
    bw.dtack = 1'b1; bw.din = 8'h5A;
    issue(3'b100, 1'b0, 2'd0, 24'h000010, 32'h0);
    step(); req = '0;
    step(); chk("wm_e1_as", 32'(bw.as), 32'h1);
    step(); chk("wm_e2_as", 32'(bw.as), 32'h1);
    step(); chk("wm_e3_as", 32'(bw.as), 32'h1);
    chk("wm_e3_ack", 32'(ackw), 32'h0);
    step();
    chk("wm_e4_ack", 32'(ackw), 32'h1);
    chk("wm_e4_rdata", rdw, 32'h0000005A);

    // DW=8 DTACK held low for five strobe cen
    b8.dtack = 1'b0; b8.din = 8'h77;
    issue(3'b001, 1'b0, 2'd0, 24'h000020, 32'h0);
    step(); req = '0;
    chk("dl_e0_rdata", rd8, 32'h000000CD);
    repeat (6) step();                                  // E1..E6
    chk("dl_e6_ack", 32'(ack8), 32'h0);
    chk("dl_e6_as", 32'(b8.as), 32'h1);
    b8.dtack = 1'b1;
    step();
    chk("dl_e7_ack", 32'(ack8), 32'h1);
    chk("dl_e7_rdata", rd8, 32'h00000077);

    // Timeout with DTACK never asserted
    b8.dtack = 1'b0;
    issue(3'b001, 1'b0, 2'd0, 24'h000030, 32'h0);
    step(); req = '0;
    ascnt = 0; ackn = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (ack8) begin ackn = n; break; end
      if (b8.as) ascnt++;
    end
    chk("to_as_cnt", 32'(ascnt), 32'd15);
    chk("to_ack_edge", 32'(ackn), 32'd16);
    chk("to_err", 32'(err8), 32'h1);
    chk("to_as", 32'(b8.as), 32'h0);
    chk("to_busy", 32'(busy8), 32'h0);

    // Halt raised mid four-byte read with address wrap
    b8.dtack = 1'b1; b8.din = 8'h01;
    issue(3'b001, 1'b0, 2'd3, 24'hFFFFFE, 32'h0);
    step(); req = '0; halt = 1'b1;
    chk("h_e0_addr", 32'(b8.addr), 32'hFFFFFE);
    step(); step(); b8.din = 8'h02;
    chk("h_e2_addr", 32'(b8.addr), 32'hFFFFFF);
    step(); step(); b8.din = 8'h03;
    chk("h_e4_addr", 32'(b8.addr), 32'h000000);
    step(); step(); b8.din = 8'h04;
    step(); step();
    chk("h_e8_ack", 32'(ack8), 32'h1);
    chk("h_e8_rdata", rd8, 32'h01020304);

    // halt blocks acceptance; so does cen low
    issue(3'b001, 1'b0, 2'd0, 24'h000040, 32'h0);
    repeat (3) step();
    chk("halt_busy", 32'(busy8), 32'h0);
    chk("halt_as", 32'(b8.as), 32'h0);
    halt = 1'b0; cen = 1'b0;
    repeat (2) step();
    chk("cen_busy", 32'(busy8), 32'h0);
    req = '0; cen = 1'b1;

    // Asynchronous reset mid-beat
    b8.dtack = 1'b0;
    issue(3'b001, 1'b1, 2'd0, 24'h000040, 32'h0000009C);
    step(); req = '0;
    step();
    chk("rs_pre_as", 32'(b8.as), 32'h1);
    chk("rs_pre_we", 32'(b8.we), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_as", 32'(b8.as), 32'h0);
    chk("rs_we", 32'(b8.we), 32'h0);
    chk("rs_busy", 32'(busy8), 32'h0);
    #1 rst_n = 1'b1;
    b8.dtack = 1'b1;
    issue(3'b001, 1'b1, 2'd0, 24'h000050, 32'h0000009C);
    step(); req = '0;
    chk("rs2_e0_as", 32'(b8.as), 32'h0);
    chk("rs2_e0_addr", 32'(b8.addr), 32'h50);
    chk("rs2_e0_dout", 32'(b8.dout), 32'h9C);
    step(); chk("rs2_e1_as", 32'(b8.as), 32'h1);
    step(); chk("rs2_e2_ack", 32'(ack8), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
